regfile_wb_arbiter: RTL

Write-back arbiter for the 32x32 register file's single write port (D, D_En, D_Addr). It accepts write requests from three producers over valid/ready handshakes and grants at most one per cycle. Producers are 0 = ALU result, 1 = load data, 2 = link/exception writes. The granted request drives a registered write bundle into the register file. A saturating contention counter is kept for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-back arbiter for the register file's single
// write port. Three producers (0 = ALU, 1 = load, 2 = link/exception)
// compete over valid/ready; at most one is granted per cycle and the
// winner is registered onto D_En/D_Addr/D.
// Optional feature macro: WB_RR_EN
//   defined   -> round-robin arbitration starting after last_grant
//   undefined -> fixed priority 0 > 1 > 2 (last_grant only records)
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_stall,
    input  logic [2:0]    req_valid,
    output logic [2:0]    req_ready,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic [DW-1:0] req_data2,
    output logic          D_En,
    output logic [AW-1:0] D_Addr,
    output logic [DW-1:0] D,
    output logic [CW-1:0] contention_cnt,
    output logic [1:0]    last_grant
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

    wb_req_t    reqs [3];
    wb_req_t    win_req;
    logic [1:0] start;
    logic [1:0] win_idx;
    logic [2:0] grant;
    logic       xfer;
    logic       multi;

    assign reqs[0] = '{addr: req_addr0, data: req_data0};
    assign reqs[1] = '{addr: req_addr1, data: req_data1};
    assign reqs[2] = '{addr: req_addr2, data: req_data2};

`ifdef WB_RR_EN
    // Search begins one past the most recent winner, wrapping mod 3.
    assign start = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
`else
    // Fixed priority: requester 0 always searched first.
    assign start = 2'd0;
`endif

    // Pick the first valid requester in search order; stall/reset mask all grants.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        logic       found;
        grant   = '0;
        win_idx = 2'd0;
        found   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, start} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                win_idx    = idx;
                found      = 1'b1;
            end
        end
        if (reset || wb_stall) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign win_req   = reqs[win_idx];
    assign multi     = (req_valid[0] & req_valid[1]) |
                       (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

    // Remember the winner; reset value 2 gives requester 0 first turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 2'd2;
        end else if (xfer) begin
            last_grant <= win_idx;
        end
    end

    // Register the granted write; R0 writes are consumed but not enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            D_En   <= 1'b0;
            D_Addr <= '0;
            D      <= '0;
        end else if (xfer) begin
            D_En   <= |win_req.addr;
            D_Addr <= win_req.addr;
            D      <= win_req.data;
        end else begin
            D_En   <= 1'b0;
        end
    end

    // Count cycles with 2+ valid requesters (stalled cycles too), saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contention_cnt <= '0;
        end else if (multi && (contention_cnt != {CW{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule
